mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Memory-access stage of the 5-stage RV32I pipeline; consumes the execute-stage pipeline register outputs and drives the data-memory bus.
- Performs loads and stores with byte/half/word lane steering, sign or zero extension, and a req/ack handshake with a timeout counter.
- Resolves the writeback value and registers it into the MEM/WB pipeline register.
- Stalls upstream stages while a bus access is outstanding.

Parameters:
- ACK_TIMEOUT, 255, maximum wait cycles for dmem_ack before the access is aborted (range 1..65535).

Ports:
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- rd_write_enable  in  1  register-file write request from execute
- rd_write_addr  in  5  destination register
- res_src  in  2  result source: 00 exec_out, 01 load data, 10 next_pc, 11 reserved (treated as 00)
- mem_write_enable  in  1  store request
- mem_width_in  in  3  funct3 width: 000 B, 001 H, 010 W, 100 BU, 101 HU
- exec_out  in  32  ALU result; byte address when accessing memory
- mem_write_data  in  32  store data (rs2)
- next_pc_in  in  32  pc+4 for JAL/JALR link
- dmem_req  out  1  bus request
- dmem_we  out  1  1 = write
- dmem_addr  out  32  word-aligned address {exec_out[31:2],2'b00}
- dmem_wdata  out  32  lane-replicated store data
- dmem_wstrb  out  4  byte strobes; 0000 on reads
- dmem_rdata  in  32  read data, valid when dmem_ack is high
- dmem_ack  in  1  access-complete strobe
- stall  out  1  hold execute and earlier stages
- rd_write_enable_out  out  1  MEM/WB write enable
- rd_write_addr_out  out  5  MEM/WB destination
- wb_data_out  out  32  MEM/WB writeback data
- bus_error_out  out  1  one-cycle pulse on timeout

Behaviour:
- Access op: access = mem_write_enable || (res_src==01). A store takes priority if both are set.
- States:
  - IDLE -> WAIT when access && !dmem_ack.
  - IDLE stays IDLE when access && dmem_ack (zero-wait access).
  - WAIT -> IDLE on dmem_ack, or when the counter reaches ACK_TIMEOUT.
- dmem_req is combinational: (IDLE && access) || WAIT. dmem_addr, dmem_we, dmem_wdata and dmem_wstrb are driven combinationally from the inputs.
- Upstream holds the inputs stable while stall=1.
- stall = dmem_req && !dmem_ack && !timeout_hit.
- Counter:
  - Cleared in IDLE.
  - Increments each WAIT cycle without ack.
  - timeout_hit = WAIT && count==ACK_TIMEOUT-1 && !dmem_ack.
  - Ack on the timeout cycle wins; no error is raised.
- Store lanes, a=exec_out[1:0]:
  - B: wdata={4{d[7:0]}}, wstrb=0001<<a.
  - H: wdata={2{d[15:0]}}, wstrb=0011<<{a[1],0}.
  - W: wdata=d, wstrb=1111.
- Load extract: lane = dmem_rdata >> (8*a).
  - B/H sign-extend bit 7/15.
  - BU/HU zero-extend.
  - W passes through.
  - Other widths are treated as W.
- Pipeline register, updated each clk edge:
  - stall=1: insert bubble (rd_write_enable_out<=0); other outputs hold.
  - Access completing on ack: rd_write_enable_out<=rd_write_enable && !store; wb_data_out<=load data for loads, exec_out for stores.
  - Timeout: rd_write_enable_out<=0; bus_error_out<=1 for exactly one cycle.
  - Non-access op: wb_data_out<=res_src==10 ? next_pc_in : exec_out.
- A write to x0 propagates as-is; the register file ignores it.
- Reset (async, rst_n=0):
  - State IDLE, counter 0.
  - rd_write_enable_out=0, rd_write_addr_out=0, wb_data_out=0, bus_error_out=0.
  - The combinational bus outputs follow the inputs.
  - Reset mid-WAIT abandons the access. No writeback is produced.

Optional Feature:
- MEM_MISALIGN_CHECK_EN
- Defined:
  - H/HU with a[0]=1, or W with a!=00, is misaligned.
  - A misaligned access is not issued (dmem_req=0, no stall).
  - It produces a bubble (rd_write_enable_out=0) and a one-cycle bus_error_out pulse.
- Undefined:
  - No check is made. Lane shift and strobe use the address bits as given.
  - Misaligned halfwords/words yield the truncated lane data or strobes.

Test Plan:
- Zero-wait load LW, exec_out=0x100, rdata=0xDEADBEEF, ack same cycle, res_src=01, rd=5 -> dmem_req=1, stall=0, next edge rd_write_enable_out=1, rd_write_addr_out=5, wb_data_out=0xDEADBEEF.
- LB exec_out=0x103, rdata=0x80112233, ack after 3 cycles -> stall high for 3 cycles with bubbles, wb_data_out=0xFFFFFF80. The same access as LBU -> 0x00000080.
- SH exec_out=0x202, data=0x0000ABCD -> dmem_we=1, dmem_addr=0x200, wdata=0xABCDABCD, wstrb=1100, rd_write_enable_out=0.
- JAL link, res_src=10, next_pc_in=0x1004, rd=1 -> no dmem_req, no stall, wb_data_out=0x1004 after one edge.
- ACK_TIMEOUT=4, load with ack never asserted -> stall for 4 cycles, then bus_error_out one-cycle pulse, rd_write_enable_out=0, state back to IDLE.
- rst_n pulled low during WAIT, then released -> all registered outputs 0. The next load completes normally.

Source files
------------

// File: rtl/mem_stage_if.sv
// Data-memory bus between the RV32I memory stage (master) and the data memory (slave).
interface mem_stage_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
        input  dmem_rdata, dmem_ack
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
        output dmem_rdata, dmem_ack
    );
endinterface

// File: rtl/mem_stage.sv
// RV32I memory-access stage: lane steering, req/ack handshake with timeout, MEM/WB register.
// Optional misaligned-access trapping is enabled by defining MEM_MISALIGN_CHECK_EN.
module mem_stage #(
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rd_write_enable,
    input  logic [4:0]  rd_write_addr,
    input  logic [1:0]  res_src,
    input  logic        mem_write_enable,
    input  logic [2:0]  mem_width_in,
    input  logic [31:0] exec_out,
    input  logic [31:0] mem_write_data,
    input  logic [31:0] next_pc_in,
    mem_stage_if.master dmem,
    output logic        stall,
    output logic        rd_write_enable_out,
    output logic [4:0]  rd_write_addr_out,
    output logic [31:0] wb_data_out,
    output logic        bus_error_out
);

    typedef enum logic {IDLE, WAIT} state_t;

    localparam logic [15:0] LAST_COUNT = 16'(ACK_TIMEOUT - 1);

    state_t      state;
    state_t      state_next;
    logic [15:0] count;

    logic        is_store;
    logic        access;
    logic        misaligned;
    logic        issue;
    logic        timeout_hit;
    logic        misalign_err;
    logic [1:0]  a;
    logic        width_b;
    logic        width_h;
    logic [31:0] lane;
    logic [31:0] load_data;
    logic [3:0]  wstrb_lanes;

    assign a        = exec_out[1:0];
    assign is_store = mem_write_enable;
    assign access   = mem_write_enable || (res_src == 2'b01);

    // funct3[1:0] picks the width class; unlisted encodings fall into the word class
    assign width_b  = (mem_width_in[1:0] == 2'b00);
    assign width_h  = (mem_width_in[1:0] == 2'b01);

`ifdef MEM_MISALIGN_CHECK_EN
    assign misaligned = access && ((width_h && a[0]) || (!width_b && !width_h && (a != 2'b00)));
`else
    assign misaligned = 1'b0;
`endif

    assign issue        = access && !misaligned;
    assign misalign_err = (state == IDLE) && access && misaligned;
    assign timeout_hit  = (state == WAIT) && (count == LAST_COUNT) && !dmem.dmem_ack;

    assign dmem.dmem_req  = ((state == IDLE) && issue) || (state == WAIT);
    assign dmem.dmem_we   = mem_write_enable;
    assign dmem.dmem_addr = {exec_out[31:2], 2'b00};
    assign dmem.dmem_wstrb = is_store ? wstrb_lanes : 4'b0000;

    assign stall = dmem.dmem_req && !dmem.dmem_ack && !timeout_hit;

    always_comb begin
        dmem.dmem_wdata = mem_write_data;
        wstrb_lanes     = 4'b1111;
        if (width_b) begin
            dmem.dmem_wdata = {4{mem_write_data[7:0]}};
            wstrb_lanes     = 4'b0001 << a;
        end else if (width_h) begin
            dmem.dmem_wdata = {2{mem_write_data[15:0]}};
            wstrb_lanes     = 4'b0011 << {a[1], 1'b0};
        end
    end

    // funct3[2] set means the unsigned variant, so it suppresses sign extension
    assign lane = dmem.dmem_rdata >> {a, 3'b000};

    always_comb begin
        load_data = lane;
        if (width_b) begin
            load_data = {{24{lane[7] & ~mem_width_in[2]}}, lane[7:0]};
        end else if (width_h) begin
            load_data = {{16{lane[15] & ~mem_width_in[2]}}, lane[15:0]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (issue && !dmem.dmem_ack) state_next = WAIT;
            WAIT:    if (dmem.dmem_ack || timeout_hit) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if ((state == WAIT) && !dmem.dmem_ack && !timeout_hit) begin
            count <= count + 16'd1;
        end else begin
            count <= '0;
        end
    end

    // A completed access never reaches the final branch, so res_src==01 needs no case there
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_write_enable_out <= 1'b0;
            rd_write_addr_out   <= '0;
            wb_data_out         <= '0;
            bus_error_out       <= 1'b0;
        end else begin
            bus_error_out <= 1'b0;
            if (stall) begin
                rd_write_enable_out <= 1'b0;
            end else if (timeout_hit || misalign_err) begin
                rd_write_enable_out <= 1'b0;
                bus_error_out       <= 1'b1;
            end else if (dmem.dmem_req) begin
                rd_write_enable_out <= rd_write_enable && !is_store;
                rd_write_addr_out   <= rd_write_addr;
                wb_data_out         <= is_store ? exec_out : load_data;
            end else begin
                rd_write_enable_out <= rd_write_enable;
                rd_write_addr_out   <= rd_write_addr;
                wb_data_out         <= (res_src == 2'b10) ? next_pc_in : exec_out;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed test-plan cases plus randomized ops
// compared every cycle against a transaction-level model of the stage.
module tb_mem_stage;

    localparam int TO = 4;

`ifdef MEM_MISALIGN_CHECK_EN
    localparam bit MIS_CHECK = 1'b1;
`else
    localparam bit MIS_CHECK = 1'b0;
`endif

    typedef struct {
        bit        rwe;
        bit [4:0]  rd;
        bit [1:0]  src;
        bit        we;
        bit [2:0]  width;
        bit [31:0] exec;
        bit [31:0] wdata;
        bit [31:0] npc;
        bit [31:0] rdata;
        int        delay;
    } op_t;

    logic        clk;
    logic        rst_n;
    logic        rd_write_enable;
    logic [4:0]  rd_write_addr;
    logic [1:0]  res_src;
    logic        mem_write_enable;
    logic [2:0]  mem_width_in;
    logic [31:0] exec_out;
    logic [31:0] mem_write_data;
    logic [31:0] next_pc_in;
    logic        stall;
    logic        rd_write_enable_out;
    logic [4:0]  rd_write_addr_out;
    logic [31:0] wb_data_out;
    logic        bus_error_out;

    mem_stage_if dmem();

    mem_stage #(.ACK_TIMEOUT(TO)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .rd_write_enable     (rd_write_enable),
        .rd_write_addr       (rd_write_addr),
        .res_src             (res_src),
        .mem_write_enable    (mem_write_enable),
        .mem_width_in        (mem_width_in),
        .exec_out            (exec_out),
        .mem_write_data      (mem_write_data),
        .next_pc_in          (next_pc_in),
        .dmem                (dmem),
        .stall               (stall),
        .rd_write_enable_out (rd_write_enable_out),
        .rd_write_addr_out   (rd_write_addr_out),
        .wb_data_out         (wb_data_out),
        .bus_error_out       (bus_error_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;
    bit check_en     = 1'b0;

    logic        exp_req, exp_stall, exp_we;
    logic [31:0] exp_addr, exp_wdata;
    logic [3:0]  exp_wstrb;
    logic        exp_rwe, exp_err;
    logic [4:0]  exp_raddr;
    logic [31:0] exp_wb;

    logic        seen_req, seen_we, seen_stall;
    logic [31:0] seen_addr, seen_wdata;
    logic [3:0]  seen_wstrb;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic bit [31:0] storeData(input bit [2:0] w, input bit [31:0] d);
        case (w)
            3'b000:  return (d & 32'h0000_00FF) * 32'h0101_0101;
            3'b001:  return (d & 32'h0000_FFFF) * 32'h0001_0001;
            default: return d;
        endcase
    endfunction

    function automatic bit [3:0] storeStrobe(input bit [2:0] w, input bit [31:0] addr);
        int a;
        a = int'(addr & 32'd3);
        case (w)
            3'b000:  return 4'(1 << a);
            3'b001:  return 4'(3 << (a & 2));
            default: return 4'hF;
        endcase
    endfunction

    function automatic bit [31:0] loadValue(input bit [2:0] w, input bit [31:0] addr, input bit [31:0] rdata);
        bit [31:0] ln;
        ln = rdata >> (8 * (addr & 32'd3));
        case (w)
            3'b000:  return (ln & 32'h80)   ? (ln | 32'hFFFF_FF00) : (ln & 32'h0000_00FF);
            3'b001:  return (ln & 32'h8000) ? (ln | 32'hFFFF_0000) : (ln & 32'h0000_FFFF);
            3'b100:  return ln & 32'h0000_00FF;
            3'b101:  return ln & 32'h0000_FFFF;
            default: return ln;
        endcase
    endfunction

    function automatic bit misalignedOp(input op_t op);
        bit odd, unaligned, acc;
        odd       = (op.exec & 32'd1) != 0;
        unaligned = (op.exec & 32'd3) != 0;
        acc       = op.we || (op.src == 2'b01);
        case (op.width)
            3'b000, 3'b100: return 1'b0;
            3'b001, 3'b101: return MIS_CHECK && acc && odd;
            default:        return MIS_CHECK && acc && unaligned;
        endcase
    endfunction

    // Drives one op until it leaves the stage; model expectations follow the handshake rules
    task automatic applyStimulus(input op_t op, output int stalls);
        bit access, mis, ack_now, to_now;
        int c;
        rd_write_enable  = op.rwe;
        rd_write_addr    = op.rd;
        res_src          = op.src;
        mem_write_enable = op.we;
        mem_width_in     = op.width;
        exec_out         = op.exec;
        mem_write_data   = op.wdata;
        next_pc_in       = op.npc;
        access = op.we || (op.src == 2'b01);
        mis    = misalignedOp(op);
        stalls = 0;
        c      = 0;
        forever begin
            ack_now = access && !mis && (c == op.delay);
            to_now  = access && !mis && !ack_now && (c == TO);
            dmem.dmem_ack   = ack_now;
            dmem.dmem_rdata = ack_now ? op.rdata : $urandom();
            exp_req   = access && !mis;
            exp_stall = exp_req && !ack_now && !to_now;
            exp_we    = op.we;
            exp_addr  = op.exec & 32'hFFFF_FFFC;
            exp_wstrb = op.we ? storeStrobe(op.width, op.exec) : 4'b0000;
            exp_wdata = storeData(op.width, op.wdata);
            @(negedge clk);
            seen_req   = dmem.dmem_req;
            seen_we    = dmem.dmem_we;
            seen_stall = stall;
            seen_addr  = dmem.dmem_addr;
            seen_wdata = dmem.dmem_wdata;
            seen_wstrb = dmem.dmem_wstrb;
            @(posedge clk);
            exp_err = 1'b0;
            if (exp_stall) begin
                exp_rwe = 1'b0;
                stalls++;
            end else if (to_now || mis) begin
                exp_rwe = 1'b0;
                exp_err = 1'b1;
            end else if (access) begin
                exp_rwe   = op.rwe && !op.we;
                exp_raddr = op.rd;
                exp_wb    = op.we ? op.exec : loadValue(op.width, op.exec, op.rdata);
            end else begin
                exp_rwe   = op.rwe;
                exp_raddr = op.rd;
                exp_wb    = (op.src == 2'b10) ? op.npc : op.exec;
            end
            #1;
            if (!exp_stall) break;
            c++;
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            checkOutput("dmem_req", 32'(dmem.dmem_req), 32'(exp_req));
            checkOutput("stall", 32'(stall), 32'(exp_stall));
            checkOutput("dmem_we", 32'(dmem.dmem_we), 32'(exp_we));
            checkOutput("dmem_addr", dmem.dmem_addr, exp_addr);
            checkOutput("dmem_wstrb", 32'(dmem.dmem_wstrb), 32'(exp_wstrb));
            if (exp_we) checkOutput("dmem_wdata", dmem.dmem_wdata, exp_wdata);
            checkOutput("rd_write_enable_out", 32'(rd_write_enable_out), 32'(exp_rwe));
            checkOutput("rd_write_addr_out", 32'(rd_write_addr_out), 32'(exp_raddr));
            checkOutput("wb_data_out", wb_data_out, exp_wb);
            checkOutput("bus_error_out", 32'(bus_error_out), 32'(exp_err));
        end
    end

    function automatic op_t makeOp(input bit rwe, input bit [4:0] rd, input bit [1:0] src, input bit we,
                                   input bit [2:0] width, input bit [31:0] exec, input bit [31:0] wdata,
                                   input bit [31:0] npc, input bit [31:0] rdata, input int delay);
        op_t op;
        op.rwe = rwe; op.rd = rd; op.src = src; op.we = we; op.width = width;
        op.exec = exec; op.wdata = wdata; op.npc = npc; op.rdata = rdata; op.delay = delay;
        return op;
    endfunction

    function automatic op_t randomOp();
        op_t op;
        bit [2:0] load_widths [8];
        load_widths = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110, 3'b111};
        op.rwe   = 1'($urandom_range(0, 1));
        op.rd    = 5'($urandom_range(0, 31));
        op.exec  = $urandom();
        op.wdata = $urandom();
        op.npc   = $urandom();
        op.rdata = $urandom();
        op.we    = 1'b0;
        op.width = 3'b010;
        op.delay = ($urandom_range(0, 6) == 0) ? -1 : int'($urandom_range(0, TO + 1));
        case ($urandom_range(0, 3))
            0: begin
                op.we    = 1'b1;
                op.src   = 2'($urandom_range(0, 3));
                op.width = 3'($urandom_range(0, 2));
            end
            1, 2: begin
                op.src   = 2'b01;
                op.width = load_widths[$urandom_range(0, 7)];
            end
            default: begin
                case ($urandom_range(0, 2))
                    0:       op.src = 2'b00;
                    1:       op.src = 2'b10;
                    default: op.src = 2'b11;
                endcase
                op.width = 3'($urandom_range(0, 7));
            end
        endcase
        return op;
    endfunction

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int stalls;
        op_t op;
        rst_n = 1'b0;
        rd_write_enable = 1'b0; rd_write_addr = '0; res_src = 2'b00; mem_write_enable = 1'b0;
        mem_width_in = 3'b010; exec_out = '0; mem_write_data = '0; next_pc_in = '0;
        dmem.dmem_ack = 1'b0; dmem.dmem_rdata = '0;
        exp_rwe = 1'b0; exp_raddr = '0; exp_wb = '0; exp_err = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset rd_write_enable_out", 32'(rd_write_enable_out), 32'd0);
        checkOutput("reset wb_data_out", wb_data_out, 32'd0);
        checkOutput("reset bus_error_out", 32'(bus_error_out), 32'd0);
        rst_n = 1'b1;
        check_en = 1'b1;

        $display("[TB] zero-wait LW");
        applyStimulus(makeOp(1'b1, 5'd5, 2'b01, 1'b0, 3'b010, 32'h100, 32'h0, 32'h0, 32'hDEADBEEF, 0), stalls);
        checkOutput("lw stalls", 32'(stalls), 32'd0);
        checkOutput("lw dmem_req", 32'(seen_req), 32'd1);
        checkOutput("lw rd_write_enable_out", 32'(rd_write_enable_out), 32'd1);
        checkOutput("lw rd_write_addr_out", 32'(rd_write_addr_out), 32'd5);
        checkOutput("lw wb_data_out", wb_data_out, 32'hDEADBEEF);

        $display("[TB] LB and LBU with three wait cycles");
        applyStimulus(makeOp(1'b1, 5'd6, 2'b01, 1'b0, 3'b000, 32'h103, 32'h0, 32'h0, 32'h80112233, 3), stalls);
        checkOutput("lb stalls", 32'(stalls), 32'd3);
        checkOutput("lb wb_data_out", wb_data_out, 32'hFFFFFF80);
        applyStimulus(makeOp(1'b1, 5'd6, 2'b01, 1'b0, 3'b100, 32'h103, 32'h0, 32'h0, 32'h80112233, 3), stalls);
        checkOutput("lbu wb_data_out", wb_data_out, 32'h00000080);

        $display("[TB] SH lane steering");
        applyStimulus(makeOp(1'b1, 5'd9, 2'b00, 1'b1, 3'b001, 32'h202, 32'h0000ABCD, 32'h0, 32'h0, 1), stalls);
        checkOutput("sh dmem_we", 32'(seen_we), 32'd1);
        checkOutput("sh dmem_addr", seen_addr, 32'h200);
        checkOutput("sh dmem_wdata", seen_wdata, 32'hABCDABCD);
        checkOutput("sh dmem_wstrb", 32'(seen_wstrb), 32'b1100);
        checkOutput("sh rd_write_enable_out", 32'(rd_write_enable_out), 32'd0);

        $display("[TB] JAL link");
        applyStimulus(makeOp(1'b1, 5'd1, 2'b10, 1'b0, 3'b010, 32'h4000, 32'h0, 32'h1004, 32'h0, 0), stalls);
        checkOutput("jal dmem_req", 32'(seen_req), 32'd0);
        checkOutput("jal stalls", 32'(stalls), 32'd0);
        checkOutput("jal wb_data_out", wb_data_out, 32'h1004);

        $display("[TB] load timeout");
        applyStimulus(makeOp(1'b1, 5'd2, 2'b01, 1'b0, 3'b010, 32'h500, 32'h0, 32'h0, 32'h0, -1), stalls);
        checkOutput("timeout stalls", 32'(stalls), 32'd4);
        checkOutput("timeout bus_error_out", 32'(bus_error_out), 32'd1);
        checkOutput("timeout rd_write_enable_out", 32'(rd_write_enable_out), 32'd0);
        applyStimulus(makeOp(1'b1, 5'd3, 2'b00, 1'b0, 3'b010, 32'h55, 32'h0, 32'h0, 32'h0, 0), stalls);
        checkOutput("error pulse width", 32'(bus_error_out), 32'd0);
        checkOutput("after timeout wb_data_out", wb_data_out, 32'h55);

        $display("[TB] reset during WAIT");
        check_en = 1'b0;
        rd_write_enable = 1'b1; rd_write_addr = 5'd7; res_src = 2'b01; mem_write_enable = 1'b0;
        mem_width_in = 3'b010; exec_out = 32'h300; dmem.dmem_ack = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        checkOutput("wait reset rd_write_enable_out", 32'(rd_write_enable_out), 32'd0);
        checkOutput("wait reset rd_write_addr_out", 32'(rd_write_addr_out), 32'd0);
        checkOutput("wait reset wb_data_out", wb_data_out, 32'd0);
        checkOutput("wait reset bus_error_out", 32'(bus_error_out), 32'd0);
        checkOutput("wait reset dmem_req follows inputs", 32'(dmem.dmem_req), 32'd1);
        res_src = 2'b00; rd_write_enable = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        exp_rwe = 1'b0; exp_raddr = '0; exp_wb = '0; exp_err = 1'b0;
        check_en = 1'b1;
        applyStimulus(makeOp(1'b1, 5'd7, 2'b01, 1'b0, 3'b010, 32'h300, 32'h0, 32'h0, 32'h12345678, 2), stalls);
        checkOutput("post reset stalls", 32'(stalls), 32'd2);
        checkOutput("post reset wb_data_out", wb_data_out, 32'h12345678);
        checkOutput("post reset rd_write_enable_out", 32'(rd_write_enable_out), 32'd1);

        $display("[TB] randomized ops");
        for (int i = 0; i < 400; i++) begin
            op = randomOp();
            applyStimulus(op, stalls);
        end

        check_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
